// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - instruction fetch controller driving an external PC register
// Optional exception redirect enabled by PC_FETCH_EXCEPTION_EN.
module pc_fetch_ctrl #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [PC_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0180
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [PC_WIDTH-1:0] PC_OUT,
    output logic [PC_WIDTH-1:0] PC_NEXT,
    output logic                IMEM_REQ,
    output logic [PC_WIDTH-1:0] IMEM_ADDR,
    input  logic                IMEM_ACK,
    input  logic [31:0]         IMEM_RDATA,
    output logic [31:0]         INSTR,
    output logic [PC_WIDTH-1:0] INSTR_PC,
    output logic                INSTR_VALID,
    input  logic                STALL,
    input  logic                BR_TAKEN,
    input  logic [PC_WIDTH-1:0] BR_TARGET,
    input  logic                JUMP,
    input  logic [PC_WIDTH-1:0] JUMP_TARGET
`ifdef PC_FETCH_EXCEPTION_EN
    ,
    input  logic                EXC,
    input  logic [PC_WIDTH-1:0] EXC_PC,
    output logic [PC_WIDTH-1:0] EPC
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

    state_t              state;
    logic                pend;
    logic [PC_WIDTH-1:0] pend_target;
    logic                redir;
    logic [PC_WIDTH-1:0] target_raw;
    logic [PC_WIDTH-1:0] target;

`ifndef PC_FETCH_EXCEPTION_EN
    logic unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    always_comb begin
        redir      = BR_TAKEN | JUMP;
        target_raw = BR_TAKEN ? BR_TARGET : JUMP_TARGET;
`ifdef PC_FETCH_EXCEPTION_EN
        if (EXC) begin
            redir      = 1'b1;
            target_raw = EXC_VECTOR;
        end
`endif
        target = {target_raw[PC_WIDTH-1:2], 2'b00};
    end

    // Request decodes straight from state so an async reset drops it at once.
    assign IMEM_REQ  = (state == FETCH);
    assign IMEM_ADDR = IMEM_REQ ? PC_OUT : '0;

    always_comb begin
        PC_NEXT = PC_OUT;
        if (!RST) begin
            PC_NEXT = RESET_VECTOR;
        end else begin
            case (state)
                IDLE:    PC_NEXT = redir ? target : RESET_VECTOR;
                FETCH: begin
                    if (IMEM_ACK) begin
                        if (redir)     PC_NEXT = target;
                        else if (pend) PC_NEXT = pend_target;
                        else           PC_NEXT = PC_OUT + PC_WIDTH'(4);
                    end
                end
                VALID:   if (redir) PC_NEXT = target;
                default: PC_NEXT = RESET_VECTOR;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= IDLE;
            INSTR       <= '0;
            INSTR_PC    <= '0;
            INSTR_VALID <= 1'b0;
            pend        <= 1'b0;
            pend_target <= '0;
`ifdef PC_FETCH_EXCEPTION_EN
            EPC         <= '0;
`endif
        end else begin
`ifdef PC_FETCH_EXCEPTION_EN
            if (EXC) EPC <= EXC_PC;
`endif
            case (state)
                IDLE: begin
                    INSTR_VALID <= 1'b0;
                    state       <= FETCH;
                end
                FETCH: begin
                    if (IMEM_ACK) begin
                        pend <= 1'b0;
                        // Any redirect seen during this fetch makes the returned word stale.
                        if (!redir && !pend) begin
                            INSTR       <= IMEM_RDATA;
                            INSTR_PC    <= PC_OUT;
                            INSTR_VALID <= 1'b1;
                            state       <= VALID;
                        end
                    end else if (redir) begin
                        pend        <= 1'b1;
                        pend_target <= target;
                    end
                end
                VALID: begin
                    if (redir || !STALL) begin
                        INSTR_VALID <= 1'b0;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_out, pc_next, imem_addr, instr, instr_pc;
    logic [31:0] imem_rdata, br_target, jump_target;
    logic        imem_req, imem_ack, instr_valid, stall, br_taken, jump;
    logic [31:0] pc_reg;
    logic        pc_force;
    logic [31:0] pc_force_val;
`ifdef PC_FETCH_EXCEPTION_EN
    logic        exc;
    logic [31:0] exc_pc, epc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // External PC register fed by PC_NEXT; the force path sets up the wrap case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_reg <= 32'h0;
        else      pc_reg <= pc_next;
    end
    assign pc_out     = pc_force ? pc_force_val : pc_reg;
    assign imem_rdata = 32'hC0DE_0000 | imem_addr;

    pc_fetch_ctrl dut (
        .CLK(clk), .RST(rst), .PC_OUT(pc_out), .PC_NEXT(pc_next),
        .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_ACK(imem_ack),
        .IMEM_RDATA(imem_rdata), .INSTR(instr), .INSTR_PC(instr_pc),
        .INSTR_VALID(instr_valid), .STALL(stall), .BR_TAKEN(br_taken),
        .BR_TARGET(br_target), .JUMP(jump), .JUMP_TARGET(jump_target)
`ifdef PC_FETCH_EXCEPTION_EN
        , .EXC(exc), .EXC_PC(exc_pc), .EPC(epc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        imem_ack = 0; stall = 0; br_taken = 0; jump = 0;
        br_target = 0; jump_target = 0; pc_force = 0; pc_force_val = 0;
`ifdef PC_FETCH_EXCEPTION_EN
        exc = 0; exc_pc = 0;
`endif
        #3;
        br_taken = 1; br_target = 32'h40;
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc_next", pc_next, 32'h0);
        br_taken = 0; br_target = 0;

        // Zero-wait fetch stream
        tick(); rst = 1; imem_ack = 1; #1;
        check("idle_req", {31'b0, imem_req}, 32'h0);
        check("idle_pc_next", pc_next, 32'h0);
        tick();
        check("f0_req", {31'b0, imem_req}, 32'h1);
        check("f0_addr", imem_addr, 32'h0);
        check("f0_pc_next", pc_next, 32'h4);
        tick();
        check("v0_valid", {31'b0, instr_valid}, 32'h1);
        check("v0_instr", instr, 32'hC0DE_0000);
        check("v0_instr_pc", instr_pc, 32'h0);
        check("v0_req", {31'b0, imem_req}, 32'h0);
        tick();
        check("f1_addr", imem_addr, 32'h4);
        check("f1_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("v1_instr", instr, 32'hC0DE_0004);
        check("v1_valid", {31'b0, instr_valid}, 32'h1);
        tick();
        check("f2_addr", imem_addr, 32'h8);

        // Stall held in VALID for five cycles
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", {31'b0, instr_valid}, 32'h1);
            check("stall_instr_pc", instr_pc, 32'h8);
            check("stall_instr", instr, 32'hC0DE_0008);
            check("stall_req", {31'b0, imem_req}, 32'h0);
        end
        stall = 0; imem_ack = 0;

        // ACK delayed three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_req", {31'b0, imem_req}, 32'h1);
            check("wait_addr", imem_addr, 32'hC);
            check("wait_pc_next", pc_next, 32'hC);
        end
        tick(); imem_ack = 1; #1;
        check("ack_addr", imem_addr, 32'hC);
        check("ack_pc_next", pc_next, 32'h10);
        tick(); imem_ack = 0;
        check("late_instr_pc", instr_pc, 32'hC);
        check("late_instr", instr, 32'hC0DE_000C);
        tick();
        check("f4_addr", imem_addr, 32'h10);

        // Branch while waiting: pending target, data discarded on ACK
        br_taken = 1; br_target = 32'h103; #1;
        check("pend_pc_next", pc_next, 32'h10);
        tick(); br_taken = 0; #1;
        check("pend_hold_addr", imem_addr, 32'h10);
        tick(); imem_ack = 1; #1;
        check("pend_ack_pc_next", pc_next, 32'h100);
        tick(); imem_ack = 0; #1;
        check("pend_discard_valid", {31'b0, instr_valid}, 32'h0);
        check("pend_new_addr", imem_addr, 32'h100);
        check("pend_new_req", {31'b0, imem_req}, 32'h1);

        // Redirect coinciding with ACK; branch beats jump
        imem_ack = 1; br_taken = 1; br_target = 32'h200; jump = 1; jump_target = 32'h300;
`ifdef PC_FETCH_EXCEPTION_EN
        exc = 1; exc_pc = 32'h1234;
        #1;
        check("prio_pc_next", pc_next, 32'h180);
        tick(); br_taken = 0; jump = 0; exc = 0; #1;
        check("epc", epc, 32'h1234);
        check("prio_addr", imem_addr, 32'h180);
        tick();
        check("prio_instr_pc", instr_pc, 32'h180);
`else
        #1;
        check("prio_pc_next", pc_next, 32'h200);
        tick(); br_taken = 0; jump = 0; #1;
        check("prio_addr", imem_addr, 32'h200);
        check("prio_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        check("prio_instr_pc", instr_pc, 32'h200);
`endif

        // Jump in VALID overrides stall, target aligned
        jump = 1; jump_target = 32'h3FF; stall = 1; #1;
        check("valid_redir_pc_next", pc_next, 32'h3FC);
        tick(); jump = 0; stall = 0; imem_ack = 0; #1;
        check("valid_redir_valid", {31'b0, instr_valid}, 32'h0);
        check("valid_redir_addr", imem_addr, 32'h3FC);

        // PC+4 wraps
        pc_force = 1; pc_force_val = 32'hFFFF_FFFC; imem_ack = 1; #1;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_next, 32'h0);
        tick(); pc_force = 0; imem_ack = 0; #1;
        check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);

        // Async reset mid-fetch, late ACK ignored
        tick();
        check("pre_rst_req", {31'b0, imem_req}, 32'h1);
        #1 rst = 0; #1;
        check("async_req", {31'b0, imem_req}, 32'h0);
        check("async_addr", imem_addr, 32'h0);
        imem_ack = 1;
        tick();
        check("late_ack_valid", {31'b0, instr_valid}, 32'h0);
        check("late_ack_req", {31'b0, imem_req}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter PC_WIDTH, default 32, SHALL set the width of all address and PC ports.
REQ-002 Parameter RESET_VECTOR, default 0, SHALL be the first fetch address after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0180, SHALL be the exception redirect address.
REQ-004 CLK  input  1  SHALL be the clock; all state updates occur on the posedge.
REQ-005 RST  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 PC_OUT  input  PC_WIDTH  SHALL be the current value of the PC register.
REQ-007 PC_NEXT  output  PC_WIDTH  SHALL be combinational and SHALL drive the PC register input every cycle.
REQ-008 IMEM_REQ  output  1  SHALL be the instruction-memory request; IMEM_ADDR  output  PC_WIDTH  SHALL be the request address.
REQ-009 IMEM_ACK  input  1  SHALL flag valid IMEM_RDATA  input  32 in the same cycle.
REQ-010 INSTR  output  32, INSTR_PC  output  PC_WIDTH, INSTR_VALID  output  1  SHALL form the fetched-instruction output.
REQ-011 STALL  input  1  SHALL mean the downstream stage does not consume INSTR this cycle.
REQ-012 BR_TAKEN  input  1, BR_TARGET  input  PC_WIDTH, JUMP  input  1, JUMP_TARGET  input  PC_WIDTH  SHALL request redirects.

Function
REQ-013 States SHALL be IDLE, FETCH, VALID; FSM state, INSTR, INSTR_PC, INSTR_VALID and redirect-pending registers are flops.
REQ-014 IDLE: PC_NEXT = RESET_VECTOR, IMEM_REQ = 0; the FSM SHALL go to FETCH unconditionally after one cycle.
REQ-015 FETCH: IMEM_REQ = 1, IMEM_ADDR = PC_OUT; REQ and ADDR SHALL stay stable until IMEM_ACK, and PC_NEXT = PC_OUT while waiting.
REQ-016 FETCH with IMEM_ACK and no pending or current redirect: INSTR <= IMEM_RDATA, INSTR_PC <= PC_OUT, INSTR_VALID <= 1, PC_NEXT = PC_OUT+4, and the FSM SHALL go to VALID.
REQ-017 VALID: INSTR_VALID = 1, PC_NEXT = PC_OUT; if STALL = 0, the FSM SHALL go to FETCH and clear INSTR_VALID; if STALL = 1, it SHALL stay in VALID with outputs held.
REQ-018 Redirect priority SHALL be EXC (when configured) > BR_TAKEN > JUMP; the selected target's low two bits SHALL be forced to 00.
REQ-019 Redirect in IDLE or VALID: PC_NEXT = target in the same cycle, INSTR_VALID <= 0, and the FSM SHALL go to FETCH.
REQ-020 Redirect in FETCH coinciding with IMEM_ACK: IMEM_RDATA SHALL be discarded and PC_NEXT = target; the FSM SHALL stay in FETCH.
REQ-021 Redirect in FETCH without IMEM_ACK: the target SHALL be latched as pending, and a later redirect SHALL overwrite it; on ACK, data SHALL be discarded, PC_NEXT = pending target, and pending SHALL clear.
REQ-022 PC+4 SHALL wrap modulo 2^PC_WIDTH, with no overflow flag.
REQ-023 Sustained throughput with zero-wait ACK and STALL = 0 SHALL be one instruction per 2 cycles.

Reset
REQ-024 While RST = 0: state = IDLE; IMEM_REQ, INSTR_VALID, INSTR, INSTR_PC, pending flag and pending target = 0; IMEM_ADDR = 0; PC_NEXT = RESET_VECTOR.
REQ-025 Reset asserted mid-fetch SHALL drop IMEM_REQ immediately (asynchronously); any late IMEM_ACK SHALL be ignored.

Configuration
REQ-026 Macro PC_FETCH_EXCEPTION_EN defined: ports EXC input 1, EXC_PC input PC_WIDTH and EPC output PC_WIDTH SHALL exist.
REQ-027 With the macro defined, EXC SHALL redirect to EXC_VECTOR per REQ-018..021, and EPC <= EXC_PC on the same edge; EPC SHALL reset to 0.
REQ-028 Macro undefined: EXC, EXC_PC and EPC SHALL be absent, EXC_VECTOR SHALL be unused, and priority SHALL be BR_TAKEN > JUMP.

Verification
REQ-029 Release reset, ACK held 1, STALL 0 -> IMEM_ADDR sequence 0x0, 0x4, 0x8; INSTR_VALID pulses every second cycle.
REQ-030 ACK delayed 3 cycles -> IMEM_REQ/IMEM_ADDR stable for 4 cycles; PC_OUT unchanged until ACK.
REQ-031 STALL = 1 for 5 cycles in VALID -> INSTR, INSTR_PC held, INSTR_VALID = 1, no new IMEM_REQ.
REQ-032 BR_TAKEN with BR_TARGET = 0x100 mid-wait, then ACK -> data discarded, INSTR_VALID stays 0, next IMEM_ADDR = 0x100.
REQ-033 BR_TAKEN and JUMP in the same cycle (targets 0x200 and 0x300) -> next fetch from 0x200; with the macro, adding EXC -> fetch from 0x180 and EPC = EXC_PC.
REQ-034 PC_OUT = 0xFFFF_FFFC with ACK -> PC_NEXT = 0x0.
